// File: rtl/seq_arbiter.sv
// Two-requester round-robin arbiter that owns a WIDTH-bit counter and
// sequences the granted command (clear, load, count N, nop) to completion.
module seq_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [1:0]       cmd_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [1:0]       cmd_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] out
);

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {OP_CLR = 2'b00, OP_LOAD = 2'b01, OP_CNT = 2'b10, OP_NOP = 2'b11} op_t;

  // arg holds the load value, or the remaining step count for COUNT
  typedef struct packed {
    op_t             op;
    logic            id;
    logic [WIDTH-1:0] arg;
  } cmd_t;

  state_t           state, state_d;
  cmd_t             cur, cur_d;
  logic             last_b, last_b_d;
  logic             gnt_a_d, gnt_b_d, done_d, done_id_d;
  logic [WIDTH-1:0] out_d;
  logic             win_b, fin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cur     <= '{op: OP_CLR, id: 1'b0, arg: '0};
      last_b  <= 1'b1;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      out     <= '0;
    end else begin
      state   <= state_d;
      cur     <= cur_d;
      last_b  <= last_b_d;
      gnt_a   <= gnt_a_d;
      gnt_b   <= gnt_b_d;
      done    <= done_d;
      done_id <= done_id_d;
      out     <= out_d;
    end
  end

  always_comb begin
    state_d   = state;
    cur_d     = cur;
    last_b_d  = last_b;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id;
    out_d     = out;
    win_b     = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        // the done cycle is a dead cycle for arbitration
        if (!done && (req_a || req_b)) begin
          win_b     = req_b && !(req_a && last_b);
          gnt_a_d   = !win_b;
          gnt_b_d   = win_b;
          cur_d.op  = op_t'(win_b ? cmd_b : cmd_a);
          cur_d.id  = win_b;
          cur_d.arg = win_b ? data_b : data_a;
          last_b_d  = win_b;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        fin = 1'b1;
        case (cur.op)
          OP_CLR:  out_d = '0;
          OP_LOAD: out_d = cur.arg;
          OP_CNT: begin
            if (cur.arg != '0) begin
              out_d     = out + 1'b1;
              cur_d.arg = cur.arg - 1'b1;
              fin       = (cur.arg == WIDTH'(1));
            end
          end
          default: ;
        endcase
        if (fin) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          done_id_d = cur.id;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == EXEC);

endmodule

// File: tb/tb_seq_arbiter.sv
// Directed plus randomized bench for seq_arbiter, checked against a
// transaction-level model of grant order, step timing and counter value.
module tb_seq_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [1:0]  cmd_a = 2'b11, cmd_b = 2'b11;
  logic [15:0] data_a = '0, data_b = '0;
  logic        gnt_a, gnt_b, busy, done, done_id;
  logic [15:0] out;

  int npass = 0;
  int ntot  = 0;

  // model state: counter value and who won last
  logic [15:0] m_out = '0;
  bit          m_last_b = 1'b1;

  seq_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .cmd_a(cmd_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .cmd_b(cmd_b), .data_b(data_b), .gnt_b(gnt_b),
    .busy(busy), .done(done), .done_id(done_id), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // executes one granted command from the cycle after the grant to done
  task automatic execute(input logic [1:0] c, input logic [15:0] d, input bit w);
    int len;
    logic [15:0] exp;
    exp = m_out;
    len = (c == 2'b10 && d != 0) ? int'(d) : 1;
    for (int k = 1; k <= len; k++) begin
      tick();
      case (c)
        2'b00:   exp = 16'h0000;
        2'b01:   exp = d;
        2'b10:   exp = (d == 0) ? m_out : m_out + 16'(k);
        default: exp = m_out;
      endcase
      chk("out", 32'(out), 32'(exp));
      chk("gnt_idle", 32'({gnt_a, gnt_b}), 32'(0));
      if (k < len) begin
        chk("busy_exec", 32'(busy), 32'(1));
        chk("done_early", 32'(done), 32'(0));
      end else begin
        chk("done", 32'(done), 32'(1));
        chk("busy_done", 32'(busy), 32'(0));
        chk("done_id", 32'(done_id), 32'(w));
      end
    end
    m_out = exp;
  endtask

  // raise the given requests in the current cycle and serve all of them
  task automatic run(input bit ae, input logic [1:0] ca, input logic [15:0] da,
                     input bit be, input logic [1:0] cb, input logic [15:0] db,
                     input bit late_b);
    bit pa, pb, w;
    req_a = ae; cmd_a = ca; data_a = da;
    req_b = be; cmd_b = cb; data_b = db;
    pa = ae; pb = be;
    while (pa || pb) begin
      tick();
      w = (pa && pb) ? !m_last_b : pb;
      chk("gnt_a", 32'(gnt_a), 32'(!w));
      chk("gnt_b", 32'(gnt_b), 32'(w));
      chk("busy_gnt", 32'(busy), 32'(1));
      chk("done_gnt", 32'(done), 32'(0));
      if (w) begin
        req_b = 1'b0; pb = 1'b0;
        execute(cb, db, 1'b1);
      end else begin
        req_a = 1'b0; pa = 1'b0;
        execute(ca, da, 1'b0);
      end
      m_last_b = w;
      if (late_b) begin
        req_b = 1'b1; pb = 1'b1; late_b = 1'b0;
      end
      if (pa || pb) begin
        tick();
        chk("no_gnt_after_done", 32'({gnt_a, gnt_b}), 32'(0));
        chk("idle_after_done", 32'(busy), 32'(0));
      end
    end
    tick();
    chk("done_pulse", 32'(done), 32'(0));
  endtask

  initial begin
    // 1: reset then LOAD from A
    tick();
    chk("rst_out", 32'(out), 32'(0));
    chk("rst_flags", 32'({gnt_a, gnt_b, busy, done, done_id}), 32'(0));
    @(negedge clk); reset = 1'b1;
    tick();
    chk("post_rst_out", 32'(out), 32'(0));
    chk("post_rst_busy", 32'(busy), 32'(0));
    run(1, 2'b01, 16'h1234, 0, 2'b11, 16'h0, 0);

    // 2: count across wrap
    run(1, 2'b01, 16'hFFFE, 0, 2'b11, 16'h0, 0);
    run(0, 2'b11, 16'h0, 1, 2'b10, 16'd3, 0);
    chk("wrap_final", 32'(out), 32'h0001);

    // 3: fairness, A B A B
    run(1, 2'b01, 16'h00AA, 1, 2'b01, 16'h00BB, 0);
    run(1, 2'b01, 16'h00AA, 1, 2'b01, 16'h00BB, 0);

    // 4: COUNT 0 and NOP leave the value alone
    run(1, 2'b01, 16'h0042, 0, 2'b11, 16'h0, 0);
    run(1, 2'b10, 16'h0000, 0, 2'b11, 16'h0, 0);
    run(0, 2'b11, 16'h0, 1, 2'b11, 16'h0, 0);
    chk("nop_keep", 32'(out), 32'h0042);

    // 5: asynchronous reset in the middle of a count
    run(1, 2'b00, 16'h0, 0, 2'b11, 16'h0, 0);
    req_a = 1'b1; cmd_a = 2'b10; data_a = 16'd10;
    tick();
    chk("cnt10_gnt", 32'(gnt_a), 32'(1));
    req_a = 1'b0;
    repeat (4) tick();
    chk("cnt10_mid", 32'(out), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'(0));
    chk("arst_flags", 32'({gnt_a, gnt_b, busy, done, done_id}), 32'(0));
    @(negedge clk); reset = 1'b1;
    m_out = '0; m_last_b = 1'b1;
    repeat (3) begin
      tick();
      chk("no_done_after_rst", 32'({busy, done}), 32'(0));
      chk("out_after_rst", 32'(out), 32'(0));
    end
    run(1, 2'b00, 16'h0, 0, 2'b11, 16'h0, 0);

    // 6: B raised during A's done cycle is granted 2 cycles later
    run(1, 2'b01, 16'h0101, 0, 2'b01, 16'h0202, 1);
    chk("late_b_val", 32'(out), 32'h0202);

    // randomized mixes
    for (int i = 0; i < 40; i++) begin
      bit ae, be;
      logic [1:0] ca, cb;
      logic [15:0] da, db;
      ae = 1'($urandom); be = 1'($urandom);
      if (!ae && !be) ae = 1'b1;
      ca = 2'($urandom); cb = 2'($urandom);
      da = (ca == 2'b10) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      db = (cb == 2'b10) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      run(ae, ca, da, be, cb, db, 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/seq_arbiter.md
# seq_arbiter

Two-requester command arbiter and sequencer for the 16-bit load/increment counter register. It owns the counter and grants the register to one of two requesters per command, round-robin. It then sequences the granted command: clear, load, or count N steps. It sits between the control units that need the shared counter and the datapath that reads its value on `out`.

## Interface

Parameters:
- `WIDTH`, 16, counter and data width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_a` in 1: requester A command request.
- `cmd_a` in 2: A opcode: 00 CLEAR, 01 LOAD, 10 COUNT, 11 NOP.
- `data_a` in WIDTH: A operand, either the load value or the step count.
- `gnt_a` out 1: one-cycle grant pulse to A.
- `req_b`, `cmd_b`, `data_b`, `gnt_b`: same as the A ports, for requester B.
- `busy` out 1: high while a command executes.
- `done` out 1: one-cycle completion pulse.
- `done_id` out 1: requester of the completed command (0 = A, 1 = B); valid only when `done` is high.
- `out` out WIDTH: counter register value.

## Operation

- States are IDLE and EXEC. `busy` = (state == EXEC).
- **Arbitration (IDLE only):**
  - Requests are sampled only when in IDLE with `done` low.
  - If exactly one `req_*` is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - The last-grant pointer resets to B, so A wins the first tie.
  - On a win:
    - the winner's `gnt_*` is registered high for one cycle;
    - `cmd` and `data` are captured into internal registers;
    - the pointer is updated;
    - the state moves to EXEC.
- **EXEC:**
  - CLEAR: `out` ← 0, then complete.
  - LOAD: `out` ← captured data, then complete.
  - COUNT N:
    - The remaining count is loaded with N at grant.
    - Each EXEC cycle does `out` ← `out` + 1 and decrements remaining.
    - The command completes on the cycle remaining reaches 0.
    - N = 0 leaves `out` unchanged and completes after one EXEC cycle.
  - NOP (11): `out` unchanged, completes after one EXEC cycle.
- **Completion:**
  - The state returns to IDLE.
  - `done` is registered high for one cycle.
  - `done_id` carries the requester ID.
  - `out` already holds the final value in that cycle.
- **Arithmetic:** modulo 2^WIDTH. 0xFFFF + 1 = 0x0000 with no flag. The remaining count is a WIDTH-bit register.
- **Requester contract:**
  - Hold `req`, `cmd` and `data` stable until `gnt` is seen.
  - Deassert `req` by the cycle after `gnt`.
  - A `req` still high after that is a new request.
- **Non-granted request:** a request that is not granted stays pending. There is no starvation: a pending request waits at most one other command.
- **Reset (any time, including mid-COUNT):**
  - `out` = 0, state = IDLE.
  - `gnt_a`, `gnt_b`, `busy`, `done`, `done_id` all = 0.
  - The pointer is set to B and the in-flight command is discarded.
  - After `reset` is released, the block samples requests in the first cycle.

## Timing

- Request high in IDLE during cycle t:
  - `gnt` and `busy` are high in cycle t+1.
  - For CLEAR, LOAD, NOP and COUNT 0, `done` is high in t+2 and `out` is updated in t+2.
  - For COUNT N ≥ 1, `out` steps in cycles t+2 through t+N+1, and `done` is high in t+N+1.
- `busy` is high from t+1 until the cycle before `done`. `busy` and `done` are never high together.
- Because requests are not sampled during the `done` cycle, the next grant is at the earliest 2 cycles after `done`. Maximum rate is one single-cycle command per 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

1. **Reset and LOAD.** Release `reset`, then `req_a`, `cmd_a`=01, `data_a`=0x1234 in cycle t. Expect `gnt_a`=1 in t+1, `done`=1, `done_id`=0 and `out`=0x1234 in t+2. Before the request, `out`=0 and `busy`=0.
2. **COUNT with wrap.** LOAD 0xFFFE, then COUNT 3 from B. Expect `out` = 0xFFFF, 0x0000, 0x0001 on consecutive cycles, and `done` with `done_id`=1 in the cycle `out`=0x0001.
3. **Arbitration fairness.** Both requests high continuously with LOAD 0x00AA (A) and LOAD 0x00BB (B), each requester dropping and re-raising after its grant. Expect grant order A, B, A, B and `out` alternating 0x00AA and 0x00BB.
4. **COUNT 0 and NOP.** From `out`=0x0042, issue COUNT 0, then cmd 11. Each gives `done` 2 cycles after its request, with `out` still 0x0042.
5. **Reset mid-operation.** Issue COUNT 10 from 0. Assert `reset` asynchronously after 4 steps, mid-cycle. Expect `out`=0, `busy`=0, `done`=0 immediately, with no `done` after release. Then CLEAR from A gives `done`, `out`=0.
6. **Request during `done` cycle.** Hold B `req` high across A's `done` cycle. Expect `gnt_b` exactly 2 cycles after A's `done`, not 1.
